// File: rtl/bp_lce_mem_arb_if.sv
// Handshake bundle between cache pipeline, LCE, memory port and the mem-port arbiter.
// Signal names keep the original port names so existing hookups translate one-to-one.
interface bp_lce_mem_arb_if #(
  parameter int pkt_width_p  = 32,
  parameter int stat_width_p = 16
);
  logic                    cache_pkt_v_i;
  logic [pkt_width_p-1:0]  cache_pkt_i;
  logic                    cache_pkt_yumi_o;
  logic                    lce_pkt_v_i;
  logic [pkt_width_p-1:0]  lce_pkt_i;
  logic                    lce_lock_i;
  logic                    lce_pkt_yumi_o;
  logic                    mem_pkt_v_o;
  logic [pkt_width_p-1:0]  mem_pkt_o;
  logic                    mem_pkt_yumi_i;
  logic                    cache_stall_o;
  logic [stat_width_p-1:0] starve_cnt_o;

  modport master (
    output cache_pkt_v_i, cache_pkt_i, lce_pkt_v_i, lce_pkt_i, lce_lock_i, mem_pkt_yumi_i,
    input  cache_pkt_yumi_o, lce_pkt_yumi_o, mem_pkt_v_o, mem_pkt_o, cache_stall_o, starve_cnt_o
  );

  modport slave (
    input  cache_pkt_v_i, cache_pkt_i, lce_pkt_v_i, lce_pkt_i, lce_lock_i, mem_pkt_yumi_i,
    output cache_pkt_yumi_o, lce_pkt_yumi_o, mem_pkt_v_o, mem_pkt_o, cache_stall_o, starve_cnt_o
  );
endinterface

// File: rtl/bp_lce_mem_arb.sv
// Arbitrates the single mem port between the cache pipeline (normal priority) and the LCE,
// with starvation escalation and multi-beat LCE locking; grant path is purely combinational.
module bp_lce_mem_arb #(
  parameter int pkt_width_p         = 32,
  parameter int timeout_max_limit_p = 4,
  parameter int stat_width_p        = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_lce_mem_arb_if.slave   io
);

  localparam int WaitW = $clog2(timeout_max_limit_p + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(timeout_max_limit_p - 1);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_STARVED,
    ST_LOCKED
  } state_e;

  state_e                  state_q, state_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [stat_width_p-1:0] starve_cnt_q, starve_cnt_d;

  logic                    normal;
  logic                    sel_cache;
  logic                    mem_v;
  logic                    cache_yumi;
  logic                    lce_yumi;
  logic                    lce_blocked;
  logic [pkt_width_p-1:0]  sel_pkt;

  always_comb begin
    normal      = (state_q == ST_NORMAL);
    sel_cache   = normal & io.cache_pkt_v_i;
    mem_v       = normal ? (io.cache_pkt_v_i | io.lce_pkt_v_i) : io.lce_pkt_v_i;
    sel_pkt     = sel_cache ? io.cache_pkt_i : io.lce_pkt_i;
    // yumi is qualified by the selected source's valid so an illegal mem yumi has no effect
    cache_yumi  = sel_cache & io.mem_pkt_yumi_i;
    lce_yumi    = ~sel_cache & io.lce_pkt_v_i & io.mem_pkt_yumi_i;
    lce_blocked = io.lce_pkt_v_i & ~lce_yumi;
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (lce_yumi && io.lce_lock_i) begin
          state_d = ST_LOCKED;
        end else if (lce_blocked) begin
          if (wait_q == WaitLast) begin
            state_d = ST_STARVED;
            if (starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ST_STARVED: begin
        if (lce_yumi) begin
          state_d = io.lce_lock_i ? ST_LOCKED : ST_NORMAL;
        end else if (!io.lce_pkt_v_i) begin
          state_d = ST_NORMAL;
        end
      end
      ST_LOCKED: begin
        if (lce_yumi && !io.lce_lock_i) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_NORMAL;
      wait_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, before the flops have been cleared.
  assign io.mem_pkt_v_o      = ~reset_i & mem_v;
  assign io.mem_pkt_o        = sel_pkt;
  assign io.cache_pkt_yumi_o = ~reset_i & cache_yumi;
  assign io.lce_pkt_yumi_o   = ~reset_i & lce_yumi;
  assign io.cache_stall_o    = ~reset_i & ~normal;
  assign io.starve_cnt_o     = reset_i ? '0 : starve_cnt_q;

  mem_yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) io.mem_pkt_yumi_i |-> io.mem_pkt_v_o
  );

endmodule

// File: tb/tb_bp_lce_mem_arb.sv
// Bench for bp_lce_mem_arb: directed scenarios plus random traffic, scoreboarded
// against a cycle-level behavioural model of the arbitration rules.
module tb_bp_lce_mem_arb;
  localparam int PW   = 8;
  localparam int TMAX = 4;
  localparam int SW   = 2;
  localparam int CNT_MAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_lce_mem_arb_if #(.pkt_width_p(PW), .stat_width_p(SW)) bus ();

  bp_lce_mem_arb #(
    .pkt_width_p(PW),
    .timeout_max_limit_p(TMAX),
    .stat_width_p(SW)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .io     (bus)
  );

  typedef struct {
    string          tag;
    logic           mv;
    logic [PW-1:0]  pkt;
    logic           cy;
    logic           ly;
    logic           st;
    logic [SW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: lce-exclusive reasons, consecutive blocked run, starvation events
  bit m_starved, m_locked;
  int m_run, m_events;

  task automatic cmp(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic cycle(input string tag, input bit r, input bit cv, input bit lv,
                       input bit lk, input bit want_yumi);
    exp_t e;
    bit excl, selc, mv, cy, ly;
    @(negedge clk);
    rst                = r;
    bus.cache_pkt_v_i  = cv;
    bus.cache_pkt_i    = PW'($urandom);
    bus.lce_pkt_v_i    = lv;
    bus.lce_pkt_i      = PW'($urandom);
    bus.lce_lock_i     = lk;
    excl = m_starved || m_locked;
    selc = !excl && cv;
    mv   = !r && (excl ? lv : (cv || lv));
    bus.mem_pkt_yumi_i = mv && want_yumi;
    cy = selc && bus.mem_pkt_yumi_i;
    ly = !selc && lv && bus.mem_pkt_yumi_i;
    e.tag = tag;
    e.mv  = mv;
    e.pkt = selc ? bus.cache_pkt_i : bus.lce_pkt_i;
    e.cy  = cy;
    e.ly  = ly;
    e.st  = !r && excl;
    e.cnt = r ? '0 : SW'(m_events);
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_starved = 0; m_locked = 0; m_run = 0; m_events = 0;
    end else if (ly) begin
      m_locked = lk; m_starved = 0; m_run = 0;
    end else if (lv) begin
      if (!excl) begin
        m_run++;
        if (m_run == TMAX) begin
          m_starved = 1;
          m_run     = 0;
          m_events  = (m_events + 1 > CNT_MAX) ? CNT_MAX : m_events + 1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      m_starved = 0;
      m_run     = 0;
    end
  endtask

  // Monitor: pops one expectation per cycle, after inputs and outputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp(e.tag, "mem_pkt_v_o", 32'(bus.mem_pkt_v_o), 32'(e.mv));
        if (e.mv) cmp(e.tag, "mem_pkt_o", 32'(bus.mem_pkt_o), 32'(e.pkt));
        cmp(e.tag, "cache_pkt_yumi_o", 32'(bus.cache_pkt_yumi_o), 32'(e.cy));
        cmp(e.tag, "lce_pkt_yumi_o", 32'(bus.lce_pkt_yumi_o), 32'(e.ly));
        cmp(e.tag, "cache_stall_o", 32'(bus.cache_stall_o), 32'(e.st));
        cmp(e.tag, "starve_cnt_o", 32'(bus.starve_cnt_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cache_pkt_v_i = 0; bus.cache_pkt_i = '0;
    bus.lce_pkt_v_i = 0; bus.lce_pkt_i = '0; bus.lce_lock_i = 0;
    bus.mem_pkt_yumi_i = 0;
    m_starved = 0; m_locked = 0; m_run = 0; m_events = 0;

    repeat (2) cycle("reset", 1, 1, 1, 0, 1);

    // Both valid, mem always consuming: cache wins 4 beats, then LCE via starvation
    repeat (6) cycle("both_yumi", 0, 1, 1, 0, 1);

    // LCE multi-beat lock with cache arriving on beat 2
    cycle("lock_b1", 0, 0, 1, 1, 1);
    cycle("lock_b2", 0, 1, 1, 1, 1);
    cycle("lock_b3", 0, 1, 1, 1, 1);
    cycle("lock_b4", 0, 1, 1, 0, 1);
    cycle("lock_after", 0, 1, 0, 0, 1);

    // Starved, then LCE withdraws before being consumed
    repeat (4) cycle("starve_enter", 0, 1, 1, 0, 0);
    cycle("lce_drop", 0, 1, 0, 0, 1);
    cycle("lce_drop_next", 0, 1, 0, 0, 1);

    // Mem stalled 10 cycles with both valid: single starvation event
    cycle("reset2", 1, 0, 0, 0, 0);
    repeat (10) cycle("mem_stall", 0, 1, 1, 0, 0);
    cycle("mem_release", 0, 1, 0, 0, 1);

    // Drive the starvation counter into saturation
    repeat (4) begin
      repeat (4) cycle("saturate", 0, 1, 1, 0, 0);
      cycle("saturate_drop", 0, 0, 0, 0, 0);
    end

    // Reset while LOCKED aborts the sequence
    cycle("lock_enter", 0, 0, 1, 1, 1);
    cycle("lock_idle", 0, 1, 0, 0, 1);
    cycle("lock_reset", 1, 1, 1, 1, 1);
    cycle("post_reset", 0, 1, 1, 0, 1);
    cycle("post_reset2", 0, 1, 0, 0, 1);

    repeat (800) begin
      cycle("random", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) != 0);
    end

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
